// File: rtl/ha_array_accumulator.sv
// Serial final-summation stage for the 4-row ha_array interface of the 8x8 approximate multipliers.
// Optional build macro HA_ACC_SATURATE_EN clamps product to 16'hFFFF when the 17-bit sum overflows.
module ha_array_accumulator #(
  parameter int ROWS      = 4,
  parameter int ROW_SHIFT = 2,
  parameter int OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [6:0]       ha_array_1_b,
  input  logic [8:0]       ha_array_1_t,
  input  logic [6:0]       ha_array_2_b,
  input  logic [8:0]       ha_array_2_t,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic             ovf
);

  localparam int ACC_W = OUT_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       cnt;
  logic [ACC_W-1:0] acc;
  logic [6:0]       b_q [ROWS];
  logic [8:0]       t_q [ROWS];

  logic             accept;
  logic [9:0]       row_val;
  logic [4:0]       shamt;
  logic [ACC_W-1:0] addend;

  assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == S_DONE);
  assign ovf       = acc[ACC_W-1];

`ifdef HA_ACC_SATURATE_EN
  assign product = acc[ACC_W-1] ? '1 : acc[OUT_W-1:0];
`else
  assign product = acc[OUT_W-1:0];
`endif

  // Row value R = t + (b << 2), weighted by 4^cnt for the row currently being added.
  always_comb begin
    row_val = 10'(t_q[cnt]) + 10'({b_q[cnt], 2'b00});
    shamt   = 5'(ROW_SHIFT) * 5'(cnt);
    addend  = ACC_W'(row_val) << shamt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < ROWS; k++) begin
        b_q[k] <= '0;
        t_q[k] <= '0;
      end
    end else if (accept) begin
      b_q[0] <= ha_array_0_b;
      t_q[0] <= ha_array_0_t;
      b_q[1] <= ha_array_1_b;
      t_q[1] <= ha_array_1_t;
      b_q[2] <= ha_array_2_b;
      t_q[2] <= ha_array_2_t;
      b_q[3] <= ha_array_3_b;
      t_q[3] <= ha_array_3_t;
    end
  end

  // A new set may be taken in the same cycle the DONE result is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc   <= '0;
            cnt   <= '0;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          acc <= acc + addend;
          cnt <= cnt + 2'd1;
          if (cnt == 2'(ROWS - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              acc   <= '0;
              cnt   <= '0;
              state <= S_ACC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Randomized and directed bench for ha_array_accumulator against a cycle-level transaction model.
// Define HA_ACC_SATURATE_EN here too when building the saturating variant.
module tb_ha_array_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic [15:0] product;
  logic [6:0]  b [4];
  logic [8:0]  t [4];

  int n_vec = 0;
  int n_bad = 0;

  ha_array_accumulator #(.ROWS(4), .ROW_SHIFT(2), .OUT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b[0]),
    .ha_array_0_t (t[0]),
    .ha_array_1_b (b[1]),
    .ha_array_1_t (t[1]),
    .ha_array_2_b (b[2]),
    .ha_array_2_t (t[2]),
    .ha_array_3_b (b[3]),
    .ha_array_3_t (t[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  int unsigned m_cnt;   // add cycles still to run
  bit          m_has;   // result waiting for hand-off
  int unsigned m_sum;

  function automatic int unsigned ref_sum();
    int unsigned s = 0;
    int unsigned w = 1;
    for (int k = 0; k < 4; k++) begin
      s += (int'(t[k]) + 4 * int'(b[k])) * w;
      w *= 4;
    end
    return s;
  endfunction

  function automatic logic [15:0] exp_prod(input int unsigned s);
`ifdef HA_ACC_SATURATE_EN
    return (s > 65535) ? 16'hFFFF : 16'(s);
`else
    return 16'(s % 65536);
`endif
  endfunction

  function automatic bit model_in_ready();
    return (m_cnt == 0 && !m_has) || (m_has && out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit rdy;
    if (!rst_n) begin
      m_cnt = 0;
      m_has = 0;
      m_sum = 0;
    end else begin
      rdy = model_in_ready();
      if (m_has && out_ready) m_has = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_has = 1;
      end
      if (in_valid && rdy) begin
        m_sum = ref_sum();
        m_cnt = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(m_has));
      check("in_ready", 32'(in_ready), 32'(model_in_ready()));
      if (m_has) begin
        check("product", 32'(product), 32'(exp_prod(m_sum)));
        check("ovf", 32'(ovf), 32'(m_sum > 65535));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic zero_rows();
    for (int k = 0; k < 4; k++) begin
      b[k] = '0;
      t[k] = '0;
    end
  endtask

  task automatic rand_rows();
    for (int k = 0; k < 4; k++) begin
      b[k] = 7'($urandom);
      t[k] = 9'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs are scrambled during ACC so the result also proves sampling at the accept edge only.
  task automatic run_directed(input string name, input logic [15:0] exp_p, input logic exp_o);
    int lat = 0;
    bit got = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      lat++;
      #1 rand_rows();
      @(negedge clk);
      if (out_valid) got = 1;
    end
    if (!got) check({name, "_timeout"}, 32'(0), 32'(1));
    check({name, "_latency"}, 32'(lat), 32'(4));
    check({name, "_product"}, 32'(product), 32'(exp_p));
    check({name, "_ovf"}, 32'(ovf), 32'(exp_o));
    idle_cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    zero_rows();
    #12;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_product", 32'(product), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    idle_cycles(2);

    // single-bit weights
    zero_rows(); t[0] = 9'h001;
    run_directed("row0_t", 16'd1, 1'b0);
    zero_rows(); b[1] = 7'h01;
    run_directed("row1_b", 16'd16, 1'b0);
    zero_rows(); t[3] = 9'h001;
    run_directed("row3_t", 16'd64, 1'b0);

    // all rows at maximum: 1019 * 85 = 86615 = 17'h15257
    for (int k = 0; k < 4; k++) begin
      b[k] = 7'h7F;
      t[k] = 9'h1FF;
    end
`ifdef HA_ACC_SATURATE_EN
    run_directed("max_rows", 16'hFFFF, 1'b1);
`else
    run_directed("max_rows", 16'h5257, 1'b1);
`endif

    // backpressure: row2 t=0xAB (2736) + row0 b=0x15 (84) = 2820
    begin
      bit got = 0;
      zero_rows(); t[2] = 9'h0AB; b[0] = 7'h15;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      rand_rows();
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (out_valid) got = 1;
      end
      if (!got) check("bp_timeout", 32'(0), 32'(1));
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("bp_hold_product", 32'(product), 32'(16'h0B04));
        check("bp_hold_valid", 32'(out_valid), 32'(1));
        check("bp_hold_in_ready", 32'(in_ready), 32'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 32'(out_valid), 32'(0));
      idle_cycles(2);
    end

    // back-to-back with in_valid held high
    begin
      int cyc = 0;
      int n = 0;
      int c [2];
      logic [15:0] p [2];
      zero_rows(); t[0] = 9'h003;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 t[0] = 9'h005;
      for (int i = 0; i < 30 && n < 2; i++) begin
        @(negedge clk);
        cyc++;
        if (out_valid) begin
          p[n] = product;
          c[n] = cyc;
          n++;
          if (n == 1) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
          end
        end
      end
      check("b2b_count", 32'(n), 32'(2));
      if (n == 2) begin
        check("b2b_first", 32'(p[0]), 32'(3));
        check("b2b_second", 32'(p[1]), 32'(5));
        check("b2b_spacing", 32'(c[1] - c[0]), 32'(5));
      end
      idle_cycles(2);
    end

    // reset during ACC discards the set
    zero_rows(); t[1] = 9'h0FF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_product", 32'(product), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_output", 32'(out_valid), 32'(0));
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 4; k++) begin
          b[k] = 7'h7F - 7'($urandom_range(0, 3));
          t[k] = 9'h1FF - 9'($urandom_range(0, 7));
        end
      end else begin
        rand_rows();
      end
    end
    idle_cycles(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
